lab_7_top: RTL and testbench
============================

LAB_7_TOP -- requirements
Module: lab_7_top

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 Port clk SHALL be an input, 1 bit wide, the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, asynchronous active-low reset (0 = reset asserted).
REQ-004 Port key_in SHALL be an input, 64 bits wide, the DES key; bit 63 is DES key bit 1.
REQ-005 Port data_in SHALL be an input, 64 bits wide, the plaintext block; bit 63 is DES bit 1.
REQ-006 Port load SHALL be an input, 1 bit wide, the capture strobe; active high, sampled on the rising clk edge.
REQ-007 Port data_out SHALL be an output, 64 bits wide, the registered ciphertext; bit 63 is DES bit 1.
REQ-008 The block SHALL have no parameters; all widths SHALL be fixed at 64.

Function
REQ-009 The block SHALL perform FIPS 46-3 DES encryption only (no decrypt mode): IP, then 16 Feistel rounds, then the final swap, then FP.
REQ-010 Key schedule: PC-1 drops parity bits 8,16,…,64; C/D left-rotate schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; PC-2 produces K1..K16.
REQ-011 Key parity bits SHALL be ignored: keys differing only in parity bits SHALL give identical ciphertext.
REQ-012 The datapath from key_in/data_in to the data_out register SHALL be purely combinational, with the 16 rounds unrolled; no internal FSM.
REQ-013 On a rising clk edge with load=1 and reset deasserted, data_out SHALL take DES(key_in, data_in) of the values present at that edge.
REQ-014 Latency SHALL be one cycle: the result is visible immediately after the capturing edge and is stable for the bench to sample on the next edge.
REQ-015 With load=0, data_out SHALL hold its last value indefinitely, regardless of key_in/data_in changes.
REQ-016 Back-to-back load=1 cycles SHALL each produce a new result, giving a throughput of one block per cycle.
REQ-017 load asserted while reset is asserted SHALL have no effect.

Reset
REQ-018 While reset=0, data_out SHALL be forced to 64'h0000000000000000 asynchronously, without waiting for clk.
REQ-019 After reset deasserts, data_out SHALL stay 0 until the first edge with load=1.
REQ-020 Asserting reset in any cycle SHALL clear data_out immediately; the first load after release SHALL give a correct result, with no history dependence.

Structure
REQ-021 A shared package des_pkg SHALL hold the IP, FP, E, P, PC-1 and PC-2 tables, the eight S-box tables and the rotate schedule as constants.
REQ-022 One sub-module des_round SHALL implement a single Feistel round (E-expand, XOR with subkey, S-boxes, P, XOR/swap); the top SHALL instantiate it 16 times.
REQ-023 Key schedule and IP/FP SHALL be combinational logic in the top; the only register SHALL be data_out.

Verification
REQ-024 Reset: hold reset=0 with load=1 and arbitrary inputs -> data_out = 0000000000000000; it stays 0 after release until load=1.
REQ-025 Variable-key vectors, plaintext 0, load=1 each cycle -> key 8000000000000000 gives 95A8D72813DAA94D; key 4000000000000000 gives 0EEC1487DD8C26D5; key 2000000000000000 gives 7AD16FFB79C45926; key 1000000000000000 gives D3746294CA6A6CF3; key 0800000000000000 gives 809F5F873C1FD761.
REQ-026 Parity independence: key 8001010101010101, plaintext 0 -> 95A8D72813DAA94D, the same as for key 8000000000000000.
REQ-027 Classic vector: key 133457799BBCDFF1, plaintext 0123456789ABCDEF -> 85E813540F0AB405.
REQ-028 Hold: load=1 with key 8000000000000000, then load=0 while key_in changes to 2000000000000000 -> data_out remains 95A8D72813DAA94D.
REQ-029 Mid-stream reset: assert reset between two loads -> data_out = 0 asynchronously; the next load gives the correct ciphertext for its inputs.

Source files
------------

// File: rtl/des_pkg.sv
// DES constant tables (IP, FP, E, P, PC-1, PC-2, S-boxes, rotate schedule)
// and the permutation helpers built on them. Table entries use DES bit
// numbering: entry value n selects DES bit n, which is vector bit (W - n).
package des_pkg;

  localparam int IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [0:47] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // Parity bits 8,16,...,64 never appear here, so they cannot affect the result.
  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each box is stored row-major: index = row*16 + col.
  localparam int SBOX [0:7][0:63] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  // Row comes from the outer bits (b5,b0), column from the inner four.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
    return 4'(SBOX[box][{b[5], b[0], b[4:1]}]);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    return (n == 1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

endpackage

// File: rtl/des_round.sv
// One DES Feistel round: L' = R, R' = L ^ P(S(E(R) ^ K)).
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic [31:0] l_out,
  output logic [31:0] r_out
);

  logic [47:0] x;
  logic [31:0] s_out;

  assign l_out = r_in;

  // Round function f: expand, key-mix, substitute (box 1 lands in the MSBs), permute.
  always_comb begin
    x     = perm_e(r_in) ^ subkey;
    s_out = '0;
    for (int s = 0; s < 8; s++) begin
      s_out = {s_out[27:0], sbox_lookup(3'(s), 6'(x >> (42 - 6 * s)))};
    end
    r_out = l_in ^ perm_p(s_out);
  end

endmodule

// File: rtl/lab_7_top.sv
// Fully unrolled single-cycle DES encryptor. Key schedule, IP, the 16
// rounds and FP are combinational; data_out is the only register.
// Strobe semantics: when load is high at a rising clk edge (reset released),
// data_out captures DES(key_in, data_in); with load low data_out holds.
module lab_7_top
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  input  logic        load,
  output logic [63:0] data_out
);

  logic [27:0] c [0:16];
  logic [27:0] d [0:16];
  logic [47:0] subkey [0:15];
  logic [31:0] l [0:16];
  logic [31:0] r [0:16];
  logic [63:0] pre_fp;

  assign {c[0], d[0]} = perm_pc1(key_in);
  assign {l[0], r[0]} = perm_ip(data_in);

  for (genvar i = 0; i < 16; i++) begin : g_round
    assign c[i+1]    = rotl28(c[i], SHIFTS[i]);
    assign d[i+1]    = rotl28(d[i], SHIFTS[i]);
    assign subkey[i] = perm_pc2({c[i+1], d[i+1]});

    des_round u_round (
      .l_in   (l[i]),
      .r_in   (r[i]),
      .subkey (subkey[i]),
      .l_out  (l[i+1]),
      .r_out  (r[i+1])
    );
  end

  // Halves are swapped after the last round before the final permutation.
  assign pre_fp = {r[16], l[16]};

  // Ciphertext register: async clear, capture on load, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= perm_fp(pre_fp);
    end
  end

endmodule

// File: tb/tb_lab_7_top.sv
// Directed bench for lab_7_top using published DES vectors.
module tb_lab_7_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] key_in = '0;
  logic [63:0] data_in = '0;
  logic        load = 1'b0;
  logic [63:0] data_out;

  int n_compared = 0;
  int n_mismatched = 0;
  logic [63:0] exp_q [$];

  lab_7_top dut (
    .clk      (clk),
    .reset    (reset),
    .key_in   (key_in),
    .data_in  (data_in),
    .load     (load),
    .data_out (data_out)
  );

  // Clock/reset block: 10 ns period; reset starts released so its fall is an event.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: present a load at the next falling edge and queue its expectation.
  task automatic drive_load(input logic [63:0] k, input logic [63:0] d, input logic [63:0] e);
    @(negedge clk);
    key_in  = k;
    data_in = d;
    load    = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    #3;
    reset   = 1'b0;
    load    = 1'b1;
    key_in  = 64'h133457799BBCDFF1;
    data_in = 64'h0123456789ABCDEF;
    #1;
    n_compared++;
    if (data_out !== 64'h0) begin
      n_mismatched++;
      $display("FAIL reset_async: data_out=%h required=%h", data_out, 64'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_compared++;
      if (data_out !== 64'h0) begin
        n_mismatched++;
        $display("FAIL reset_load_ignored[%0d]: data_out=%h required=%h", i, data_out, 64'h0);
      end
    end
    reset = 1'b1;
    load  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key_in  = {$urandom, $urandom};
      data_in = {$urandom, $urandom};
      @(negedge clk);
      n_compared++;
      if (data_out !== 64'h0) begin
        n_mismatched++;
        $display("FAIL reset_release_hold[%0d]: data_out=%h required=%h", i, data_out, 64'h0);
      end
    end
  endtask

  // Back-to-back loads: one new ciphertext every cycle.
  task automatic test_var_key;
    logic [63:0] keys [0:4];
    logic [63:0] exps [0:4];
    logic [63:0] e;
    keys = '{64'h8000000000000000, 64'h4000000000000000, 64'h2000000000000000,
             64'h1000000000000000, 64'h0800000000000000};
    exps = '{64'h95A8D72813DAA94D, 64'h0EEC1487DD8C26D5, 64'h7AD16FFB79C45926,
             64'hD3746294CA6A6CF3, 64'h809F5F873C1FD761};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive_load(keys[i], 64'h0, exps[i]);
      else @(negedge clk);
      if (i > 0) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_compared++;
        if (data_out !== e) begin
          n_mismatched++;
          $display("FAIL var_key[%0d]: data_out=%h required=%h", i - 1, data_out, e);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_parity;
    drive_load(64'h8001010101010101, 64'h0, 64'h95A8D72813DAA94D);
    @(negedge clk);
    load = 1'b0;
    n_compared++;
    if (data_out !== exp_q[0]) begin
      n_mismatched++;
      $display("FAIL parity: data_out=%h required=%h", data_out, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_classic;
    drive_load(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
    @(negedge clk);
    load = 1'b0;
    n_compared++;
    if (data_out !== exp_q[0]) begin
      n_mismatched++;
      $display("FAIL classic: data_out=%h required=%h", data_out, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_hold;
    drive_load(64'h8000000000000000, 64'h0, 64'h95A8D72813DAA94D);
    @(negedge clk);
    load   = 1'b0;
    key_in = 64'h2000000000000000;
    n_compared++;
    if (data_out !== 64'h95A8D72813DAA94D) begin
      n_mismatched++;
      $display("FAIL hold_load: data_out=%h required=%h", data_out, 64'h95A8D72813DAA94D);
    end
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_in = {$urandom, $urandom};
      n_compared++;
      if (data_out !== 64'h95A8D72813DAA94D) begin
        n_mismatched++;
        $display("FAIL hold[%0d]: data_out=%h required=%h", i, data_out, 64'h95A8D72813DAA94D);
      end
    end
  endtask

  task automatic test_mid_reset;
    drive_load(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
    @(negedge clk);
    n_compared++;
    if (data_out !== 64'h85E813540F0AB405) begin
      n_mismatched++;
      $display("FAIL mid_first: data_out=%h required=%h", data_out, 64'h85E813540F0AB405);
    end
    void'(exp_q.pop_front());
    #2;
    reset = 1'b0;
    #1;
    n_compared++;
    if (data_out !== 64'h0) begin
      n_mismatched++;
      $display("FAIL mid_async_clear: data_out=%h required=%h", data_out, 64'h0);
    end
    @(negedge clk);
    n_compared++;
    if (data_out !== 64'h0) begin
      n_mismatched++;
      $display("FAIL mid_reset_held: data_out=%h required=%h", data_out, 64'h0);
    end
    reset = 1'b1;
    load  = 1'b0;
    drive_load(64'h4000000000000000, 64'h0, 64'h0EEC1487DD8C26D5);
    @(negedge clk);
    load = 1'b0;
    n_compared++;
    if (data_out !== 64'h0EEC1487DD8C26D5) begin
      n_mismatched++;
      $display("FAIL mid_after_reset: data_out=%h required=%h", data_out, 64'h0EEC1487DD8C26D5);
    end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_var_key();
    test_parity();
    test_classic();
    test_hold();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
